wsled_multi_serializer: RTL and testbench

Parametrised WS2812-family LED line driver: accepts a pixel stream tagged with a channel number and serialises it onto up to CHANNELS independent single-wire LED outputs concurrently. It is the next-generation replacement for the fixed four-output, 24-bit LED back end behind the UDP receive path. It adds selectable channel count, RGB or RGBW pixel width, programmable bit and latch timing, per-channel output inversion, and per-channel busy and underrun status.

---
 rtl/wsled_multi_serializer.sv | 199 +++++++++++++++++++
 tb/tb_wsled_multi_serializer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wsled_multi_serializer.sv
// wsled_multi_serializer
// Multi-channel WS2812-family LED line driver. A single pixel stream, tagged
// with a channel number, is steered into one holding register per channel.
// Each channel then serialises its pixels MSB first onto its own
// single-wire output. A '1' bit is high for T1H clocks and a '0' bit is high
// for T0H clocks; every bit lasts T_BIT clocks. After the pixel marked last,
// the line is held low for T_RST clocks so the LEDs latch the frame.
//
// Ports
//   clk            in   system clock
//   reset_n        in   synchronous, active-low reset
//   in_valid       in   pixel word valid
//   in_ready       out  holding register of in_channel is free
//                       (always 1 for out-of-range channels, 0 in reset)
//   in_data        in   PIXEL_BITS pixel word, sent MSB first
//   in_channel     in   CW-bit target channel
//   in_last        in   final pixel of a frame on that channel
//   wsled_out      out  CHANNELS LED data lines (logical level ^ INVERT)
//   busy           out  CHANNELS channel is sending, waiting or latching
//   underrun       out  CHANNELS sticky mid-frame starvation flags
//   underrun_clear in   one-cycle pulse clearing all underrun flags
module wsled_multi_serializer #(
  parameter int CHANNELS = 4,
  parameter int PIXEL_BITS = 24,
  parameter int T_BIT = 63,
  parameter int T0H = 20,
  parameter int T1H = 40,
  parameter int T_RST = 15000,
  parameter logic [CHANNELS-1:0] INVERT = '0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIXEL_BITS-1:0] in_data,
  input  logic [CW-1:0]         in_channel,
  input  logic                  in_last,
  output logic [CHANNELS-1:0]   wsled_out,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   underrun,
  input  logic                  underrun_clear
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } state_t;

  logic [CHANNELS-1:0] sel_s;
  logic [CHANNELS-1:0] full_s;

  // An out-of-range channel matches no select line, so it reads as ready
  // and the word is silently dropped.
  assign in_ready = reset_n & ~|(sel_s & full_s);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t                state_r;
    logic [PIXEL_BITS-1:0] hold_data_r;
    logic                  hold_last_r;
    logic                  hold_full_r;
    logic [PIXEL_BITS-1:0] shift_r;
    logic                  cur_last_r;
    logic [5:0]            bit_cnt_r;
    logic [15:0]           timer_r;
    logic                  line_r;
    logic                  busy_r;
    logic                  underrun_r;
    logic                  wr_s;
    logic                  bit_end_s;
    logic                  pixel_done_s;
    logic                  load_s;
    logic                  enter_wait_s;
    logic [15:0]           high_time_s;

    assign sel_s[i]  = (in_channel == CW'(i));
    assign full_s[i] = hold_full_r;
    assign wr_s      = in_valid & in_ready & sel_s[i];

    assign bit_end_s    = (state_r == SEND) && (timer_r == 16'(T_BIT - 1));
    assign pixel_done_s = bit_end_s && (bit_cnt_r == 6'(PIXEL_BITS - 1));
    // Holding register is consumed from IDLE/WAIT, or at the final edge of a
    // non-last pixel so the next pixel follows with no gap.
    assign load_s = hold_full_r & ((state_r == IDLE) | (state_r == WAIT) |
                                   (pixel_done_s & ~cur_last_r));
    assign enter_wait_s = pixel_done_s & ~cur_last_r & ~hold_full_r;
    assign high_time_s  = shift_r[PIXEL_BITS-1] ? 16'(T1H) : 16'(T0H);

    // Holding register fill/drain and the sticky underrun flag.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        hold_full_r <= 1'b0;
        hold_data_r <= '0;
        hold_last_r <= 1'b0;
        underrun_r  <= 1'b0;
      end else begin
        if (wr_s) begin
          hold_full_r <= 1'b1;
          hold_data_r <= in_data;
          hold_last_r <= in_last;
        end else if (load_s) begin
          hold_full_r <= 1'b0;
        end
        // A new starvation event wins over a simultaneous clear.
        if (enter_wait_s) begin
          underrun_r <= 1'b1;
        end else if (underrun_clear) begin
          underrun_r <= 1'b0;
        end
      end
    end

    // Channel state machine with registered line and busy outputs.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_r    <= IDLE;
        shift_r    <= '0;
        cur_last_r <= 1'b0;
        bit_cnt_r  <= 6'd0;
        timer_r    <= 16'd0;
        line_r     <= INVERT[i];
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            line_r <= INVERT[i];
            if (hold_full_r) begin
              shift_r    <= hold_data_r;
              cur_last_r <= hold_last_r;
              bit_cnt_r  <= 6'd0;
              timer_r    <= 16'd0;
              busy_r     <= 1'b1;
              state_r    <= SEND;
            end
          end
          SEND: begin
            // The line register lags the timer by one clock, which is why
            // the first high level appears two edges after the handshake.
            line_r <= (timer_r < high_time_s) ^ INVERT[i];
            if (bit_end_s) begin
              timer_r <= 16'd0;
              if (pixel_done_s) begin
                bit_cnt_r <= 6'd0;
                if (cur_last_r) begin
                  state_r <= LATCH;
                end else if (hold_full_r) begin
                  shift_r    <= hold_data_r;
                  cur_last_r <= hold_last_r;
                end else begin
                  state_r <= WAIT;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                shift_r   <= {shift_r[PIXEL_BITS-2:0], 1'b0};
              end
            end else begin
              timer_r <= timer_r + 16'd1;
            end
          end
          WAIT: begin
            line_r <= INVERT[i];
            if (hold_full_r) begin
              shift_r    <= hold_data_r;
              cur_last_r <= hold_last_r;
              bit_cnt_r  <= 6'd0;
              timer_r    <= 16'd0;
              state_r    <= SEND;
            end
          end
          LATCH: begin
            // Entered on the edge that starts the last bit's final low clock;
            // counting to T_RST yields exactly T_RST further low clocks.
            line_r <= INVERT[i];
            if (timer_r == 16'(T_RST)) begin
              timer_r <= 16'd0;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              timer_r <= timer_r + 16'd1;
            end
          end
          default: begin
            line_r  <= INVERT[i];
            busy_r  <= 1'b0;
            timer_r <= 16'd0;
            state_r <= IDLE;
          end
        endcase
      end
    end

    assign wsled_out[i] = line_r;
    assign busy[i]      = busy_r;
    assign underrun[i]  = underrun_r;
  end

endmodule

// File: tb/tb_wsled_multi_serializer.sv
// Directed self-checking bench for wsled_multi_serializer.
// Instance a: defaults (4 ch, RGB, T_RST 15000).
// Instance b: RGBW, INVERT 4'b0010, short latch.
// Instance c: 5 channels so an out-of-range channel number is representable.
module tb_wsled_multi_serializer;

  localparam int TB = 63;
  localparam logic [3:0] B_INV = 4'b0010;
  localparam int B_RST = 200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic        in_valid = 1'b0, in_last = 1'b0, underrun_clear = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic [1:0]  in_channel = '0;
  logic [3:0]  wsled_out, busy, underrun;

  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_in_ready;
  logic [31:0] b_in_data = '0;
  logic [1:0]  b_in_channel = '0;
  logic [3:0]  b_wsled_out, b_busy, b_underrun;

  logic        c_in_valid = 1'b0, c_in_ready;
  logic [23:0] c_in_data = '0;
  logic [2:0]  c_in_channel = '0;
  logic [4:0]  c_wsled_out, c_busy, c_underrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wsled_multi_serializer dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_channel(in_channel), .in_last(in_last),
    .wsled_out(wsled_out), .busy(busy), .underrun(underrun),
    .underrun_clear(underrun_clear));

  wsled_multi_serializer #(.PIXEL_BITS(32), .INVERT(B_INV), .T_RST(B_RST)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_channel(b_in_channel), .in_last(b_in_last),
    .wsled_out(b_wsled_out), .busy(b_busy), .underrun(b_underrun),
    .underrun_clear(1'b0));

  wsled_multi_serializer #(.CHANNELS(5), .T_RST(50)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_channel(c_in_channel), .in_last(1'b1),
    .wsled_out(c_wsled_out), .busy(c_busy), .underrun(c_underrun),
    .underrun_clear(1'b0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Logical line level of instance a or b.
  function automatic logic line_of(input int inst, input int ch);
    if (inst == 0) return wsled_out[ch];
    else return b_wsled_out[ch] ^ B_INV[ch];
  endfunction

  // Handshake on instance a; leaves in_valid high, returns #1 after the edge.
  task automatic push(input int ch, input logic [23:0] data, input logic last);
    int n;
    n = 0;
    in_channel = 2'(ch);
    in_data = data;
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) check("push_timeout", 64'd0, 64'd1);
    step();
  endtask

  // Samples nbits bit periods, MSB first, and compares each whole period.
  task automatic check_bits(input int inst, input int ch, input logic [31:0] data,
                            input int nbits, input string tag);
    for (int k = nbits - 1; k >= 0; k--) begin
      logic [63:0] obs, exp;
      int th;
      obs = '0;
      exp = '0;
      th = data[k] ? 40 : 20;
      for (int t = 0; t < TB; t++) begin
        step();
        obs[t] = line_of(inst, ch);
        exp[t] = (t < th);
      end
      check($sformatf("%s_b%0d", tag, k), obs, exp);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, nb;
    logic [63:0] obs, exp;

    // Reset state
    repeat (3) step();
    check("rst_out", wsled_out, 4'b0000);
    check("rst_busy", busy, 4'b0000);
    check("rst_urun", underrun, 4'b0000);
    check("rst_ready", in_ready, 1'b0);
    check("rst_b_out", b_wsled_out, B_INV);
    check("rst_b_busy", b_busy, 4'b0000);
    reset_n = 1'b1;
    step();
    check("ready_after_rst", in_ready, 1'b1);

    // Single RGB pixel with last on channel 0, then the latch period
    push(0, 24'hA50F00, 1'b1);
    in_valid = 1'b0;
    step();
    check("t1_pre_low", wsled_out[0], 1'b0);
    check("t1_busy", busy[0], 1'b1);
    check_bits(0, 0, 32'h00A50F00, 24, "t1");
    hi = 0; nb = 0;
    for (int t = 0; t < 15000; t++) begin
      step();
      if (wsled_out[0]) hi++;
      if (!busy[0]) nb++;
    end
    check("t1_latch_high", hi, 0);
    check("t1_latch_notbusy", nb, 0);
    step();
    check("t1_idle_busy", busy[0], 1'b0);

    // Three back-to-back pixels on channel 2 with in_valid held high
    push(2, 24'hFF00AA, 1'b0);
    fork
      begin
        check("t2_stall1", in_ready, 1'b0);
        push(2, 24'h123456, 1'b0);
        check("t2_stall2", in_ready, 1'b0);
        push(2, 24'h800001, 1'b1);
        in_valid = 1'b0;
      end
      begin
        step();
        check("t2_pre_low", wsled_out[2], 1'b0);
        check_bits(0, 2, 32'h00FF00AA, 24, "t2p1");
        check_bits(0, 2, 32'h00123456, 24, "t2p2");
        check_bits(0, 2, 32'h00800001, 24, "t2p3");
      end
    join
    check("t2_urun", underrun[2], 1'b0);

    // Underrun on channel 1, clear, then set and clear in the same cycle
    push(1, 24'h0F0F0F, 1'b0);
    in_valid = 1'b0;
    step();
    check_bits(0, 1, 32'h000F0F0F, 24, "t3a");
    check("t3_urun_set", underrun[1], 1'b1);
    check("t3_busy_wait", busy[1], 1'b1);
    hi = 0;
    for (int t = 0; t < 500; t++) begin
      step();
      if (wsled_out[1]) hi++;
    end
    check("t3_gap_low", hi, 0);
    underrun_clear = 1'b1;
    step();
    underrun_clear = 1'b0;
    check("t3_urun_clr", underrun[1], 1'b0);
    push(1, 24'hC3C3C3, 1'b0);
    in_valid = 1'b0;
    step();
    check_bits(0, 1, 32'h0061E1E1, 23, "t3b");
    obs = '0; exp = '0;
    for (int t = 0; t < TB - 1; t++) begin
      step();
      obs[t] = wsled_out[1];
      exp[t] = (t < 40);
    end
    underrun_clear = 1'b1;
    step();
    underrun_clear = 1'b0;
    obs[TB-1] = wsled_out[1];
    check("t3b_b0", obs, exp);
    check("t3_set_wins", underrun[1], 1'b1);
    underrun_clear = 1'b1;
    step();
    underrun_clear = 1'b0;

    // Out-of-range channel on a 5-channel instance
    c_in_channel = 3'd7;
    c_in_data = 24'hFFFFFF;
    c_in_valid = 1'b1;
    check("t4_ready", c_in_ready, 1'b1);
    step();
    c_in_valid = 1'b0;
    hi = 0;
    for (int t = 0; t < 200; t++) begin
      step();
      if (c_wsled_out != 5'd0 || c_busy != 5'd0) hi++;
    end
    check("t4_no_activity", hi, 0);

    // RGBW pixel on inverted channel 1 of instance b
    b_in_channel = 2'd1;
    b_in_data = 32'h80000001;
    b_in_last = 1'b1;
    b_in_valid = 1'b1;
    check("t5_ready", b_in_ready, 1'b1);
    step();
    b_in_valid = 1'b0;
    step();
    check("t5_idle_phys_high", b_wsled_out[1], 1'b1);
    check_bits(1, 1, 32'h80000001, 32, "t5");
    hi = 0;
    for (int t = 0; t < B_RST; t++) begin
      step();
      if (!b_wsled_out[1] || !b_busy[1]) hi++;
    end
    check("t5_latch", hi, 0);
    step();
    check("t5_busy_drop", b_busy[1], 1'b0);
    check("t5_phys_idle", b_wsled_out, B_INV);

    // Reset during bit 10 of a channel 3 pixel, then a clean pixel
    push(3, 24'hFFFFFF, 1'b1);
    in_valid = 1'b0;
    step();
    repeat (10 * TB + 5) step();
    check("t6_mid_high_or_busy", busy[3], 1'b1);
    reset_n = 1'b0;
    step();
    check("t6_rst_out", wsled_out, 4'b0000);
    check("t6_rst_busy", busy, 4'b0000);
    check("t6_rst_ready", in_ready, 1'b0);
    check("t6_rst_urun", underrun, 4'b0000);
    check("t6_rst_b_out", b_wsled_out, B_INV);
    reset_n = 1'b1;
    step();
    check("t6_ready", in_ready, 1'b1);
    push(3, 24'h5A5A5A, 1'b1);
    in_valid = 1'b0;
    step();
    check("t6_pre_low", wsled_out[3], 1'b0);
    check_bits(0, 3, 32'h005A5A5A, 24, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
